mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It executes
//  mult/multu/div/divu over multiple cycles and owns the HI/LO registers
//  (mthi/mtlo write them, mfhi/mflo read them). It drives the busy signal that the
//  hazard/stall unit consumes as mulBusy; the stall unit then holds any
//  mult/div/mf/mt instruction in D.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after a mult/multu start
//  DIV_CYCLES   10  busy cycles after a div/divu start
// PORTS
//  clk      in   1   single clock; all state updates on the rising edge
//  reset    in   1   asynchronous, active-low reset
//  md_op    in   4   decoded EX-stage op (encodings in shared pkg); MD_NONE = idle
//  src_a    in   32  rs operand, already forwarded
//  src_b    in   32  rt operand, already forwarded
//  busy     out  1   to the stall unit (mulBusy)
//  hi       out  32  architectural HI
//  lo       out  32  architectural LO
//  md_out   out  32  mfhi -> hi, mflo -> lo, otherwise 0; feeds the EX result mux
// BEHAVIOUR
//  - Reset (reset==0, asynchronous): hi=0, lo=0, cnt=0, pending result=0.
//    busy drops to 0 immediately. An operation in flight is discarded and never
//    commits.
//  - start = md_op in {MULT,MULTU,DIV,DIVU} && cnt==0.
//  - busy = start | (cnt!=0). busy is combinational in the start cycle, so the
//    following D-stage md instruction stalls with no bubble gap.
//  - On a start edge:
//    - Latch the full result into pend_hi/pend_lo.
//    - Load cnt with MULT_CYCLES or DIV_CYCLES (4-bit counter, parameters <= 15).
//  - Each cycle with cnt!=0: cnt decrements. On the edge where cnt goes 1 -> 0,
//    hi<=pend_hi and lo<=pend_lo. The result is visible N cycles after the start edge.
//  - mult: signed 32x32 -> 64 (hi = [63:32], lo = [31:0]). multu: unsigned.
//  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the
//    dividend. divu: unsigned.
//  - Divide by zero (src_b==0): the unit still goes busy for DIV_CYCLES. hi/lo stay
//    unchanged at commit (pend = current hi/lo).
//  - Overflow case 0x80000000 / 0xFFFFFFFF (div): lo = 0x80000000, hi = 0.
//  - mthi/mtlo: write src_a to hi/lo on the next edge, only when cnt==0. An mt op
//    while cnt!=0 is ignored; the stall unit guarantees this never occurs, and
//    assertions flag it.
//  - A start op while cnt!=0 is ignored; same assertion applies.
//  - md_out is combinational from the current hi/lo. It does not bypass pending
//    results; the stall unit blocks mf while busy.
//  - No other state: the unit is an IDLE/BUSY machine encoded by cnt==0 / cnt!=0.
// STRUCTURE
//  - Shared pkg: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO,
//    MD_MFHI, MD_MFLO. The D/E decoder and the stall unit use the same encodings.
//  - Single file, no sub-module. The datapath is a behavioural */÷, latched at start;
//    the counter models latency.
// TESTING
//  1. mult a=0xFFFFFFFF b=2 -> busy=1 in start cycle + 5 cycles;
//     then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//  2. multu a=0xFFFFFFFF b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles;
//     hi/lo unchanged during busy.
//  3. div a=-7 b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     divu a=7 b=2 -> lo=3, hi=1.
//  4. Preload hi=0x11, lo=0x22; divu b=0 -> busy 10 cycles; hi=0x11, lo=0x22 after.
//  5. mthi a=0xABCD then mflo/mfhi -> md_out=0xABCD on mfhi next cycle.
//     mtlo issued during busy -> lo unaffected.
//  6. Start mult, assert reset low on cycle 3 -> busy=0, hi=lo=0 immediately.
//     Release reset -> no late commit; a new div starts normally.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// ============================================================================
// Module : mul_div_unit_pkg
// Brief  : Shared MD op encodings used by the decoder, stall unit and MD unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mul_div_unit_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  function automatic logic is_md_start(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_write(input md_op_e op);
    return is_md_start(op) || (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module : mul_div_unit
// Brief  : Multi-cycle mult/div unit owning HI/LO; result latched at start,
//          committed when the latency counter expires.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES     = 5,
  parameter int DIV_CYCLES      = 10,
  parameter bit ASSERT_PROTOCOL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  md_op_e      md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi, r_lo, r_pend_hi, r_pend_lo;

  logic             w_idle, w_start, w_b_zero, w_div_ovf;
  logic [31:0]      w_div_b, w_q_s, w_r_s, w_q_u, w_r_u;
  logic [63:0]      w_prod_s, w_prod_u;
  logic [31:0]      w_res_hi, w_res_lo;
  logic [CNT_W-1:0] w_load;

  assign w_idle  = (r_cnt == '0);
  assign w_start = is_md_start(md_op) && w_idle;
  assign busy    = w_start || !w_idle;

  // Low 64 bits of a sign-extended product are the exact signed product.
  assign w_prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

  // A zero divisor is replaced so the dividers never see it; the result is discarded.
  assign w_b_zero  = (src_b == 32'd0);
  assign w_div_b   = w_b_zero ? 32'd1 : src_b;
  assign w_div_ovf = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
  assign w_q_s     = 32'($signed(src_a) / $signed(w_div_b));
  assign w_r_s     = 32'($signed(src_a) % $signed(w_div_b));
  assign w_q_u     = src_a / w_div_b;
  assign w_r_u     = src_a % w_div_b;

  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    w_load   = c_div_load;
    case (md_op)
      MD_MULT: begin
        {w_res_hi, w_res_lo} = w_prod_s;
        w_load               = c_mult_load;
      end
      MD_MULTU: begin
        {w_res_hi, w_res_lo} = w_prod_u;
        w_load               = c_mult_load;
      end
      MD_DIV: begin
        if (w_div_ovf) begin
          w_res_hi = 32'd0;
          w_res_lo = 32'h8000_0000;
        end else if (!w_b_zero) begin
          w_res_hi = w_r_s;
          w_res_lo = w_q_s;
        end
      end
      MD_DIVU: begin
        if (!w_b_zero) begin
          w_res_hi = w_r_u;
          w_res_lo = w_q_u;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else if (w_start) begin
      r_pend_hi <= w_res_hi;
      r_pend_lo <= w_res_lo;
      r_cnt     <= w_load;
    end else if (!w_idle) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (md_op == MD_MTHI) begin
      r_hi <= src_a;
    end else if (md_op == MD_MTLO) begin
      r_lo <= src_a;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

  always_comb begin
    md_out = 32'd0;
    if (md_op == MD_MFHI) md_out = r_hi;
    else if (md_op == MD_MFLO) md_out = r_lo;
  end

  generate
    if (ASSERT_PROTOCOL) begin : g_protocol_check
      // The stall unit must never let a start or mt op reach EX while busy.
      always @(posedge clk) begin
        if (reset && !w_idle) begin
          assert (!is_md_write(md_op))
            else $error("mul_div_unit: md op %0d issued while busy", md_op);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire
